// File: rtl/sprite_pkg.sv
// Shared sprite/frame-memory types: palette-index pixel and packed row word.
package sprite_pkg;

  localparam int PIX_W = 3;
  localparam int NPIX  = 16;
  localparam int ROW_W = PIX_W * NPIX;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [ROW_W-1:0] row_t;

  // Palette index 0 is transparent; used to pad the tail of a flushed row.
  localparam pixel_t PIX_TRANSPARENT = 3'b000;

endpackage

// File: rtl/pixel_pack.sv
// Serial-to-parallel packer: gathers NPIX palette-index pixels into one row
// word. The first pixel lands in the lowest slot so the word replays in
// arrival order through the sprite-row shift unloader. A flush closes a
// partial row with transparent padding. The output is a single-entry
// register that can be refilled in the same cycle it drains.
module pixel_pack
  import sprite_pkg::*;
#(
  parameter int PIX_W = sprite_pkg::PIX_W,
  parameter int NPIX  = sprite_pkg::NPIX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_pixel,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [PIX_W*NPIX-1:0] out_data,
  input  logic                  out_ready,
  output logic [4:0]            fill_count
);

  localparam int             W     = PIX_W * NPIX;
  localparam logic [4:0]     LAST  = 5'(NPIX - 1);
  localparam logic [PIX_W-1:0] PAD = PIX_W'(PIX_TRANSPARENT);
  localparam logic [W-1:0]   BLANK = {NPIX{PAD}};

  logic [W-1:0] asm_q;
  logic [W-1:0] merged;
  logic         flush_pend;
  logic         slot_free;
  logic         is_last;
  logic         accept;
  logic         flush_req;
  logic         complete;

  // Handshake decode and the assembly word with this cycle's pixel merged in.
  // The last slot and a waiting flush are only blocked while the output
  // register is occupied and not draining this cycle.
  always_comb begin
    slot_free = !out_valid || out_ready;
    is_last   = (fill_count == LAST);
    in_ready  = !(is_last && out_valid && !out_ready) &&
                !(flush_pend && out_valid && !out_ready);
    accept    = in_valid && in_ready;
    flush_req = flush || flush_pend;
    merged    = asm_q;
    if (accept) begin
      merged = asm_q | (W'(in_pixel) << (PIX_W * fill_count));
    end
    // An empty assembly register never closes, so a bare flush is ignored.
    complete  = (accept && is_last) ||
                (flush_req && (accept || fill_count != 5'd0));
  end

  // Assembly register, fill counter, pending flush and the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q      <= BLANK;
      fill_count <= 5'd0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (complete && slot_free) begin
      // Unfilled slots are already the pad value since asm is cleared on close.
      out_data   <= merged;
      out_valid  <= 1'b1;
      asm_q      <= BLANK;
      fill_count <= 5'd0;
      flush_pend <= 1'b0;
    end else begin
      if (accept) begin
        asm_q      <= merged;
        fill_count <= fill_count + 5'd1;
      end
      // Only a flush can complete into a full slot; a 16th pixel is held off.
      if (complete) begin
        flush_pend <= 1'b1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_pack.sv
// Bench for pixel_pack: table of pixel sequences with expected row words,
// plus hand sequences for backpressure, pending flush and async reset.
module tb_pixel_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_pixel;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [47:0] out_data;
  logic        out_ready;
  logic [4:0]  fill_count;

  int n_chk  = 0;
  int n_fail = 0;
  int words  = 0;
  int pushes = 0;
  logic [47:0] sb[$];

  typedef struct {
    int          n;
    int          start;
    int          step;
    int          fmode;   // 0: no flush, 1: flush with last pixel, 2: flush after
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[7];

  pixel_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [47:0] w);
    sb.push_back(w);
    pushes++;
  endtask

  // Scoreboard: every consumed word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      words++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h required none", out_data);
      end else begin
        check("out_word", out_data, sb.pop_front());
      end
    end
  end

  task automatic beat(input logic [2:0] p, input logic fl);
    int c;
    c = 0;
    in_valid = 1'b1;
    in_pixel = p;
    flush    = fl;
    @(negedge clk);
    while (!in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_queue", 48'(sb.size()), 48'd0);
  endtask

  initial begin
    vecs[0] = '{16, 0, 1, 0, 48'hFAC688_FAC688};
    vecs[1] = '{ 3, 5, 1, 2, 48'h0000_0000_01F5};
    vecs[2] = '{16, 7, 0, 1, 48'hFFFF_FFFF_FFFF};
    vecs[3] = '{ 1, 6, 0, 1, 48'h0000_0000_0006};
    vecs[4] = '{16, 1, 0, 0, 48'h2492_4924_9249};
    vecs[5] = '{ 1, 4, 0, 2, 48'h0000_0000_0004};
    vecs[6] = '{16, 7, 7, 0, 48'h0539_7705_3977};

    reset = 1'b1; in_valid = 1'b0; in_pixel = 3'd0; flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_out_data", out_data, 48'd0);
    check("rst_fill", 48'(fill_count), 48'd0);
    check("rst_in_ready", 48'(in_ready), 48'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Table-driven words with out_ready held high.
    for (int v = 0; v < 7; v++) begin
      push(vecs[v].exp);
      for (int i = 0; i < vecs[v].n; i++)
        beat(3'((vecs[v].start + i * vecs[v].step) % 8),
             (vecs[v].fmode == 1) && (i == vecs[v].n - 1));
      if (vecs[v].fmode == 2) do_flush();
      drain();
      check("vec_fill_zero", 48'(fill_count), 48'd0);
    end

    // Flush with nothing buffered produces no word.
    do_flush();
    repeat (3) begin
      @(negedge clk);
      check("empty_flush_no_word", 48'(out_valid), 48'd0);
    end

    // Backpressure: A held, B stalls at 15 pixels until the slot drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(48'h4924_9249_2492);
    for (int i = 0; i < 16; i++) beat(3'd2, 1'b0);
    for (int i = 0; i < 15; i++) beat(3'd3, 1'b0);
    push(48'h6DB6_DB6D_B6DB);
    in_valid = 1'b1; in_pixel = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 48'(in_ready), 48'd0);
      check("bp_fill", 48'(fill_count), 48'd15);
      check("bp_hold_a", out_data, 48'h4924_9249_2492);
      check("bp_valid", 48'(out_valid), 48'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 48'(in_ready), 48'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b_valid", 48'(out_valid), 48'd1);
    check("bp_b_data", out_data, 48'h6DB6_DB6D_B6DB);
    drain();

    // Pending flush behind a held word.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(48'h2492_4924_9249);
    for (int i = 0; i < 16; i++) beat(3'd1, 1'b0);
    beat(3'd3, 1'b0);
    beat(3'd4, 1'b0);
    do_flush();
    check("pend_in_ready", 48'(in_ready), 48'd0);
    check("pend_fill", 48'(fill_count), 48'd2);
    do_flush();
    @(negedge clk);
    check("pend2_in_ready", 48'(in_ready), 48'd0);
    check("pend2_hold", out_data, 48'h2492_4924_9249);
    push(48'h0000_0000_0023);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("pend_fill_zero", 48'(fill_count), 48'd0);

    // Async reset mid-word discards held and partial data.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(3'd5, 1'b0);
    for (int i = 0; i < 9; i++) beat(3'd2, 1'b0);
    check("pre_reset_fill", 48'(fill_count), 48'd9);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", 48'(out_valid), 48'd0);
    check("async_fill", 48'(fill_count), 48'd0);
    check("async_out_data", out_data, 48'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push(48'hDB6D_B6DB_6DB6);
    for (int i = 0; i < 16; i++) beat(3'd6, 1'b0);
    drain();

    repeat (4) @(posedge clk);
    #1;
    check("word_count", 48'(words), 48'(pushes));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_pack.md
Name: pixel_pack

Overview:
- Serial-to-parallel packer for 3-bit palette-index pixels. It is the inverse of the sprite-row shift unloader.
- Collects 16 pixels, one per accepted beat, and emits one 48-bit row word for writing into sprite/frame memory.
- Bit placement makes a packed word replay in the original pixel order when it is reloaded into the unloader:
  - first pixel received goes to [2:0];
  - the 16th goes to [47:45].
- Sits between the Avalon/software pixel-write path and the sprite-row RAM write port.

Parameters:
- PIX_W, 3: bits per pixel (palette index).
- NPIX, 16: pixels per packed word. out_data width is PIX_W*NPIX = 48.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_pixel is valid this cycle.
- in_pixel, input, PIX_W: pixel value.
- in_ready, output, 1: the block accepts in_pixel this cycle.
- flush, input, 1: single-cycle request to close a partial word, zero-padded.
- out_valid, output, 1: out_data holds a completed word.
- out_data, output, PIX_W*NPIX: packed word.
- out_ready, input, 1: the consumer takes out_data this cycle.
- fill_count, output, 5: pixels currently held in the assembly register (0..NPIX-1).

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - out_valid=0, out_data=0, fill_count=0;
  - assembly register=0, flush_pend=0.
  - in_ready=1 after reset.
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
  - out_data and out_valid are registered outputs.
  - out_data is stable while out_valid=1 and out_ready=0.
- Accepted pixel k (k = fill_count) is written to asm[PIX_W*k +: PIX_W], then fill_count increments.
- Word completion occurs in either of two cases:
  - a pixel is accepted with fill_count==NPIX-1;
  - a flush is pending with fill_count>0.
- Output slot free = !out_valid || out_ready (the slot drains in the same cycle).
- On completion with the slot free:
  - out_data <= completed word, with the current-cycle pixel merged and unfilled slots forced to 0;
  - out_valid <= 1;
  - asm <= 0, fill_count <= 0, flush_pend <= 0.
- in_ready = !(fill_count==NPIX-1 && out_valid && !out_ready) && !(flush_pend && out_valid && !out_ready).
  - The 16th pixel is never accepted without a place to go.
  - No pixels are accepted while a flush waits.
- Latency: completing beat at edge N gives out_valid=1 after edge N.
- Back-to-back throughput: one pixel per cycle sustained while out_ready=1.
- Flush rules:
  - flush with fill_count==0 and no pixel accepted the same cycle: ignored, no empty word.
  - flush together with an accepted pixel: the pixel is included first, then the word closes and is padded.
  - flush with fill_count==NPIX-1 and a pixel accepted: this is a normal full word, no extra word.
  - flush while the output slot is full: sets flush_pend, which holds until the slot frees, then completes.
  - flush while flush_pend is already set: no additional effect.
- No overflow or underflow is possible by construction. in_valid while in_ready=0 has no effect.
- out_valid drops to 0 after a consume unless a new word completes the same cycle, in which case it stays 1 with the new data.
- Reset mid-word discards the partial word and any pending flush.

Decomposition:
- Shared package sprite_pkg holds:
  - localparams PIX_W=3, NPIX=16, ROW_W=48;
  - typedef pixel_t (logic [2:0]);
  - typedef row_t (logic [47:0]);
  - constant PIX_TRANSPARENT=3'b0, used as the pad value.
- No sub-module. The single-entry output register is inline.

Test Plan:
- Full word round trip:
  - Stimulus: after reset, drive pixels 0,1,...,7,0,...,7 with in_valid=1 for 16 cycles, out_ready=1.
  - Response: out_valid pulses for one cycle with out_data=48'hFAC688_FAC688, and fill_count returns to 0.
- Partial flush:
  - Stimulus: pixels 5,6,7, then flush.
  - Response: out_data=48'h0000_0000_01F5, out_valid=1.
  - Stimulus: flush again with fill_count=0.
  - Response: no new word.
- Backpressure stall:
  - Stimulus: hold out_ready=0, complete word A, then send 15 pixels of word B.
  - Response: in_ready=0 with fill_count=15, and out_data stays A.
  - Stimulus: raise out_ready.
  - Response: A is consumed, the 16th pixel is accepted that cycle, and B appears next cycle.
- Pending flush:
  - Stimulus: out_ready=0 with a word held, 2 pixels (3,4) buffered, then flush.
  - Response: flush_pend holds and in_ready=0.
  - Stimulus: out_ready=1.
  - Response: the old word is consumed, then out_data=48'h0000_0000_0023.
- Simultaneous flush and 16th pixel:
  - Stimulus: 16 pixels of 7, with flush on the last.
  - Response: exactly one word, 48'hFFFF_FFFF_FFFF.
- Async reset:
  - Stimulus: assert reset mid-clock after 9 pixels.
  - Response: out_valid=0 and fill_count=0 immediately.
  - Stimulus: 16 pixels after release.
  - Response: a clean word with no residue.
